// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending machine.
//   state_e          : controller states (idle, holding credit, vending, paying change)
//   NICKEL/DIME/...  : coin values in nickel units (1 unit = 5c)
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StVend,
    StChange
  } state_e;

  localparam int unsigned NICKEL  = 1;
  localparam int unsigned DIME    = 2;
  localparam int unsigned QUARTER = 5;

endpackage

// File: rtl/change_dispenser.sv
// Combinational change-coin selector: pays the largest coin that fits into the
// remaining credit, one coin per cycle.
//   credit      : remaining credit in nickel units
//   dime        : pay a dime this cycle
//   nickel      : pay a nickel this cycle
//   done        : nothing left to pay
//   credit_next : credit after this cycle's payout
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic                dime,
  output logic                nickel,
  output logic                done,
  output logic [CREDIT_W-1:0] credit_next
);

  always_comb begin
    dime        = 1'b0;
    nickel      = 1'b0;
    done        = 1'b0;
    credit_next = credit;
    if (credit >= CREDIT_W'(DIME)) begin
      dime        = 1'b1;
      credit_next = credit - CREDIT_W'(DIME);
    end else if (credit == CREDIT_W'(NICKEL)) begin
      nickel      = 1'b1;
      credit_next = credit - CREDIT_W'(NICKEL);
    end else begin
      done = 1'b1;
    end
  end

endmodule

// File: rtl/multi_item_vendor.sv
// Multi-item vending machine controller with per-item stock and change payout.
//   clock, reset                    : rising-edge clock, synchronous active-high reset
//   nickel_in/dime_in/quarter_in    : one-cycle coin-insert pulses (1/2/5 units)
//   sel_valid, sel_item             : purchase request for one item
//   cancel                          : refund the whole credit
//   dispense, dispense_item         : one-cycle vend pulse and the item vended
//   nickel_out, dime_out            : one-cycle change-coin pulses
//   credit                          : current credit in nickel units
//   busy                            : vending or paying change
//   coin_reject, sold_out           : one-cycle status pulses
module multi_item_vendor
  import vend_pkg::*;
#(
  parameter int unsigned                 N_ITEMS     = 4,
  parameter int unsigned                 CREDIT_W    = 6,
  parameter int unsigned                 MAX_CREDIT  = 40,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {N_ITEMS{CREDIT_W'(3)}},
  parameter int unsigned                 STOCK_W     = 4,
  parameter int unsigned                 STOCK_INIT  = 5,
  localparam int unsigned                SEL_W       = $clog2(N_ITEMS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_item,
  output logic                nickel_out,
  output logic                dime_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sold_out
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];

  logic                dispense_d, nickel_d, dime_d, busy_d, coin_reject_d, sold_out_d;
  logic [SEL_W-1:0]    dispense_item_d;

  // Input decode
  logic                any_coin, one_coin, coin_fits;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                item_ok;
  logic [CREDIT_W-1:0] item_price;
  logic [STOCK_W-1:0]  item_stock;

  logic                accepting, cancel_acc, sel_sold, sel_vend, coin_acc;
  logic                chg_dime, chg_nickel, chg_done;
  logic [CREDIT_W-1:0] chg_credit_next;

  change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .credit      (credit),
    .dime        (chg_dime),
    .nickel      (chg_nickel),
    .done        (chg_done),
    .credit_next (chg_credit_next)
  );

  always_comb begin
    coin_val = '0;
    unique case ({quarter_in, dime_in, nickel_in})
      3'b001:  coin_val = CREDIT_W'(NICKEL);
      3'b010:  coin_val = CREDIT_W'(DIME);
      3'b100:  coin_val = CREDIT_W'(QUARTER);
      default: coin_val = '0;
    endcase
  end

  assign any_coin   = nickel_in | dime_in | quarter_in;
  assign one_coin   = $onehot({quarter_in, dime_in, nickel_in});
  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits  = credit_sum <= (CREDIT_W + 1)'(MAX_CREDIT);

  // Item lookup; sel_item codes with no matching item leave item_ok low.
  always_comb begin
    item_ok    = 1'b0;
    item_price = '0;
    item_stock = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (sel_item == SEL_W'(i)) begin
        item_ok    = 1'b1;
        item_price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
        item_stock = stock_q[i];
      end
    end
  end

  // Per-cycle arbitration: cancel > selection > coin. A selection that vends or
  // reports sold-out consumes the cycle; an unaffordable one falls through to the coin.
  assign accepting  = (state_q == StIdle) || (state_q == StCredit);
  assign cancel_acc = accepting && cancel && (credit != '0);
  assign sel_sold   = accepting && !cancel_acc && sel_valid && item_ok && (item_stock == '0);
  assign sel_vend   = accepting && !cancel_acc && sel_valid && item_ok && (item_stock != '0) &&
                      (credit >= item_price);
  assign coin_acc   = accepting && !cancel_acc && !sel_sold && !sel_vend && one_coin &&
                      coin_fits;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (sel_vend && (sel_item == SEL_W'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
    unique case (state_q)
      StIdle, StCredit: begin
        if (cancel_acc) begin
          state_d = StChange;
        end else if (sel_vend) begin
          state_d  = StVend;
          credit_d = credit - item_price;
        end else if (coin_acc) begin
          state_d  = StCredit;
          credit_d = credit_sum[CREDIT_W-1:0];
        end
      end
      StVend:   state_d = (credit != '0) ? StChange : StIdle;
      StChange: begin
        if (chg_done) state_d = StIdle;
        else          credit_d = chg_credit_next;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    dispense_d      = sel_vend;
    dispense_item_d = sel_vend ? sel_item : '0;
    dime_d          = (state_q == StChange) && chg_dime;
    nickel_d        = (state_q == StChange) && chg_nickel;
    busy_d          = (state_d == StVend) || (state_d == StChange);
    coin_reject_d   = any_coin && !coin_acc;
    sold_out_d      = sel_sold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      credit        <= '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      dispense      <= 1'b0;
      dispense_item <= '0;
      nickel_out    <= 1'b0;
      dime_out      <= 1'b0;
      busy          <= 1'b0;
      coin_reject   <= 1'b0;
      sold_out      <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit        <= credit_d;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
      dispense      <= dispense_d;
      dispense_item <= dispense_item_d;
      nickel_out    <= nickel_d;
      dime_out      <= dime_d;
      busy          <= busy_d;
      coin_reject   <= coin_reject_d;
      sold_out      <= sold_out_d;
    end
  end

endmodule

// File: tb/tb_multi_item_vendor.sv
// Randomized plus directed bench for multi_item_vendor at default parameters,
// checked cycle by cycle against a behavioural model of the vending rules.
module tb_multi_item_vendor;

  localparam int N_ITEMS    = 4;
  localparam int MAX_CREDIT = 40;
  localparam int PRICE      = 3;
  localparam int STOCK_INIT = 5;

  localparam int PH_NORMAL = 0;
  localparam int PH_VEND   = 1;
  localparam int PH_REFUND = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       nickel_in = 1'b0, dime_in = 1'b0, quarter_in = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       nickel_out, dime_out;
  logic [5:0] credit;
  logic       busy, coin_reject, sold_out;

  always #5 clock = ~clock;

  multi_item_vendor dut (
    .clock         (clock),
    .reset         (reset),
    .nickel_in     (nickel_in),
    .dime_in       (dime_in),
    .quarter_in    (quarter_in),
    .sel_valid     (sel_valid),
    .sel_item      (sel_item),
    .cancel        (cancel),
    .dispense      (dispense),
    .dispense_item (dispense_item),
    .nickel_out    (nickel_out),
    .dime_out      (dime_out),
    .credit        (credit),
    .busy          (busy),
    .coin_reject   (coin_reject),
    .sold_out      (sold_out)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  // Behavioural model
  int m_credit;
  int m_phase;
  int m_stock [N_ITEMS];
  int e_disp, e_item, e_nick, e_dime, e_busy, e_rej, e_sold;

  task automatic model_step(input bit [2:0] coins_qdn, input bit s, input int item,
                            input bit c, input bit r);
    int coins, val;
    e_disp = 0; e_item = 0; e_nick = 0; e_dime = 0; e_rej = 0; e_sold = 0;
    if (r) begin
      m_credit = 0;
      m_phase  = PH_NORMAL;
      for (int i = 0; i < N_ITEMS; i++) m_stock[i] = STOCK_INIT;
      e_busy = 0;
      return;
    end
    coins = int'(coins_qdn[0]) + int'(coins_qdn[1]) + int'(coins_qdn[2]);
    val   = int'(coins_qdn[0]) * 1 + int'(coins_qdn[1]) * 2 + int'(coins_qdn[2]) * 5;
    if (m_phase == PH_NORMAL) begin
      if (c && m_credit > 0) begin
        m_phase = PH_REFUND;
        e_rej   = int'(coins > 0);
      end else if (s && item < N_ITEMS && m_stock[item] == 0) begin
        e_sold = 1;
        e_rej  = int'(coins > 0);
      end else if (s && item < N_ITEMS && m_credit >= PRICE) begin
        e_disp = 1;
        e_item = item;
        m_credit -= PRICE;
        m_stock[item] -= 1;
        m_phase = PH_VEND;
        e_rej   = int'(coins > 0);
      end else if (coins == 1 && m_credit + val <= MAX_CREDIT) begin
        m_credit += val;
      end else begin
        e_rej = int'(coins > 0);
      end
    end else if (m_phase == PH_VEND) begin
      e_rej   = int'(coins > 0);
      m_phase = (m_credit > 0) ? PH_REFUND : PH_NORMAL;
    end else begin
      e_rej = int'(coins > 0);
      if (m_credit >= 2) begin
        e_dime = 1;
        m_credit -= 2;
      end else if (m_credit == 1) begin
        e_nick = 1;
        m_credit -= 1;
      end else begin
        m_phase = PH_NORMAL;
      end
    end
    e_busy = int'(m_phase != PH_NORMAL);
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge and compare.
  task automatic step(input bit [2:0] coins_qdn, input bit s, input int item,
                      input bit c, input bit r);
    {quarter_in, dime_in, nickel_in} = coins_qdn;
    sel_valid = s;
    sel_item  = 2'(item);
    cancel    = c;
    reset     = r;
    @(posedge clock);
    model_step(coins_qdn, s, item, c, r);
    #1;
    check_eq("credit",        int'(credit),        m_credit);
    check_eq("dispense",      int'(dispense),      e_disp);
    check_eq("dispense_item", int'(dispense_item), e_item);
    check_eq("nickel_out",    int'(nickel_out),    e_nick);
    check_eq("dime_out",      int'(dime_out),      e_dime);
    check_eq("busy",          int'(busy),          e_busy);
    check_eq("coin_reject",   int'(coin_reject),   e_rej);
    check_eq("sold_out",      int'(sold_out),      e_sold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Run idle cycles until the machine is free, bounded.
  task automatic drain();
    int k;
    k = 0;
    while (busy && k < 40) begin
      idle(1);
      k++;
    end
    check_eq("drain_done", int'(busy), 0);
  endtask

  int dimes;

  initial begin
    step(3'b000, 1'b0, 0, 1'b0, 1'b1);
    step(3'b111, 1'b1, 2, 1'b1, 1'b1);  // inputs during reset are ignored
    check_eq("reset_credit", int'(credit), 0);

    // Quarter, buy item 0, get a dime back.
    step(3'b100, 1'b0, 0, 1'b0, 1'b0);
    check_eq("q_credit", int'(credit), 5);
    step(3'b000, 1'b1, 0, 1'b0, 1'b0);
    check_eq("buy0_dispense", int'(dispense), 1);
    check_eq("buy0_credit", int'(credit), 2);
    idle(2);
    check_eq("buy0_dime", int'(dime_out), 1);
    idle(1);
    check_eq("buy0_idle", int'(busy), 0);

    // Two coins in one cycle are refused.
    step(3'b011, 1'b0, 0, 1'b0, 1'b0);
    check_eq("dual_reject", int'(coin_reject), 1);
    check_eq("dual_credit", int'(credit), 0);

    // Fill to 38, overflow quarter, then cancel for 19 dimes.
    for (int i = 0; i < 7; i++) step(3'b100, 1'b0, 0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 0, 1'b0, 1'b0);
    step(3'b001, 1'b0, 0, 1'b0, 1'b0);
    check_eq("fill_credit", int'(credit), 38);
    step(3'b100, 1'b0, 0, 1'b0, 1'b0);
    check_eq("over_reject", int'(coin_reject), 1);
    check_eq("over_credit", int'(credit), 38);
    step(3'b000, 1'b0, 0, 1'b1, 1'b0);
    dimes = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      idle(1);
      dimes += int'(dime_out);
    end
    check_eq("refund_dimes", dimes, 19);
    check_eq("refund_credit", int'(credit), 0);

    // Sell out item 1 with exact change.
    for (int k = 0; k < 5; k++) begin
      step(3'b001, 1'b0, 0, 1'b0, 1'b0);
      step(3'b010, 1'b0, 0, 1'b0, 1'b0);
      step(3'b000, 1'b1, 1, 1'b0, 1'b0);
      check_eq("exact_dispense", int'(dispense), 1);
      check_eq("exact_item", int'(dispense_item), 1);
      idle(1);
    end
    step(3'b001, 1'b0, 0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 0, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1, 1'b0, 1'b0);
    check_eq("sold_out_pulse", int'(sold_out), 1);
    check_eq("sold_out_credit", int'(credit), 3);

    // Cancel wins over a simultaneous selection.
    step(3'b000, 1'b1, 0, 1'b1, 1'b0);
    check_eq("cancel_no_disp", int'(dispense), 0);
    idle(1);
    check_eq("cancel_dime", int'(dime_out), 1);
    idle(1);
    check_eq("cancel_nickel", int'(nickel_out), 1);
    idle(1);

    // Reset mid-change with credit 4 drops the credit and restocks.
    step(3'b010, 1'b0, 0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 0, 1'b0, 1'b1);
    check_eq("rst_chg_credit", int'(credit), 0);
    idle(2);
    check_eq("rst_chg_nodime", int'(dime_out), 0);
    step(3'b001, 1'b0, 0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 0, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1, 1'b0, 1'b0);
    check_eq("restock_dispense", int'(dispense), 1);
    drain();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit [2:0] cq;
      bit       s, c, r;
      cq[0] = ($urandom_range(0, 99) < 15);
      cq[1] = ($urandom_range(0, 99) < 15);
      cq[2] = ($urandom_range(0, 99) < 12);
      s     = ($urandom_range(0, 99) < 15);
      c     = ($urandom_range(0, 99) < 5);
      r     = ($urandom_range(0, 199) < 1);
      step(cq, s, int'($urandom_range(0, N_ITEMS - 1)), c, r);
    end
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
